seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_scan.sv | 134 +++++++++++++
 tb/tb_seg_display_scan.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Classifier result display: decodes accepted segment codes into a four-deep history
// and time-multiplexes that history onto a common-anode display with anti-ghosting blanking.
module seg_display_scan #(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic       seg_valid,
    input  logic       clear,
    output logic [7:0] seg_out,
    output logic [3:0] an_out,
    output logic [3:0] digit_idx,
    output logic       err,
    output logic [7:0] result_cnt
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

    // Returns {valid, class}; unrecognised codes come back as {0, 4'hF}.
    function automatic logic [4:0] decode_seg(input logic [7:0] code);
        case (code)
            8'hC0:   decode_seg = {1'b1, 4'd0};
            8'hF9:   decode_seg = {1'b1, 4'd1};
            8'hA4:   decode_seg = {1'b1, 4'd2};
            8'hB0:   decode_seg = {1'b1, 4'd3};
            8'h99:   decode_seg = {1'b1, 4'd4};
            8'h92:   decode_seg = {1'b1, 4'd5};
            8'h82:   decode_seg = {1'b1, 4'd6};
            8'hF8:   decode_seg = {1'b1, 4'd7};
            8'h80:   decode_seg = {1'b1, 4'd8};
            8'h90:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = {1'b0, 4'hF};
        endcase
    endfunction

    logic [DIV_W-1:0]                div_q, div_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [NUM_DIGITS-1:0][7:0]      hist_q, hist_d;
    logic [3:0]                      digit_idx_q, digit_idx_d;
    logic [7:0]                      result_cnt_q, result_cnt_d;
    logic                            err_q, err_d;
    logic [7:0]                      seg_out_q, seg_out_d;
    logic [3:0]                      an_out_q, an_out_d;
    logic [4:0]                      dec_s;

    // Scan timing and registered display drive, derived from the current scan state.
    always_comb begin
        div_d     = div_q;
        ptr_d     = ptr_q;
        seg_out_d = 8'hFF;
        an_out_d  = 4'hF;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            if (ptr_q == PTR_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
        // The first two cycles of each slot are dead time so the previous digit fully turns off.
        if (div_q <= DIV_W'(1)) begin
            seg_out_d = 8'hFF;
            an_out_d  = 4'hF;
        end else begin
            seg_out_d = hist_q[ptr_q];
            an_out_d  = ~(4'b0001 << ptr_q);
        end
    end

    // Result acceptance: clear beats a strobe, invalid codes only raise err.
    always_comb begin
        hist_d       = hist_q;
        digit_idx_d  = digit_idx_q;
        result_cnt_d = result_cnt_q;
        err_d        = 1'b0;
        dec_s        = decode_seg(seg_in);
        if (clear) begin
            hist_d       = {NUM_DIGITS{8'hFF}};
            digit_idx_d  = 4'hF;
            result_cnt_d = 8'd0;
        end else if (seg_valid) begin
            if (dec_s[4]) begin
                hist_d      = {hist_q[NUM_DIGITS-2:0], seg_in};
                digit_idx_d = dec_s[3:0];
                if (result_cnt_q == 8'hFF) begin
                    result_cnt_d = result_cnt_q;
                end else begin
                    result_cnt_d = result_cnt_q + 8'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            ptr_q        <= '0;
            hist_q       <= {NUM_DIGITS{8'hFF}};
            digit_idx_q  <= 4'hF;
            result_cnt_q <= 8'd0;
            err_q        <= 1'b0;
            seg_out_q    <= 8'hFF;
            an_out_q     <= 4'hF;
        end else begin
            div_q        <= div_d;
            ptr_q        <= ptr_d;
            hist_q       <= hist_d;
            digit_idx_q  <= digit_idx_d;
            result_cnt_q <= result_cnt_d;
            err_q        <= err_d;
            seg_out_q    <= seg_out_d;
            an_out_q     <= an_out_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign an_out     = an_out_q;
    assign digit_idx  = digit_idx_q;
    assign err        = err_q;
    assign result_cnt = result_cnt_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized bench for seg_display_scan against a timeline-based reference model
// (scan position derived from the number of edges since reset).
module tb_seg_display_scan;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] seg_in;
    logic       seg_valid;
    logic       clear;
    logic [7:0] seg_out;
    logic [3:0] an_out;
    logic [3:0] digit_idx;
    logic       err;
    logic [7:0] result_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_scan #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .clear      (clear),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .err        (err),
        .result_cnt (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: edges since reset, history list, latest class, count, error flag.
    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int unsigned m_k;
    logic [7:0]  m_hist [4];
    logic [3:0]  m_idx;
    int          m_cnt;
    logic        m_err;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int class_of(input logic [7:0] code);
        class_of = -1;
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == code) class_of = i;
        end
    endfunction

    // One clock: drive inputs, advance the model, then sample just after the edge.
    task automatic step(input logic r, input logic c, input logic v, input logic [7:0] s);
        int cls;
        int phase;
        int slot;
        rst = r; clear = c; seg_valid = v; seg_in = s;
        if (r) begin
            e_seg = 8'hFF; e_an = 4'hF;
            for (int i = 0; i < 4; i++) m_hist[i] = 8'hFF;
            m_idx = 4'hF; m_cnt = 0; m_err = 1'b0; m_k = 0;
        end else begin
            phase = m_k % CLK_DIV;
            slot  = (m_k / CLK_DIV) % 4;
            if (phase < 2) begin
                e_seg = 8'hFF; e_an = 4'hF;
            end else begin
                e_seg = m_hist[slot];
                e_an  = 4'hF;
                e_an[slot] = 1'b0;
            end
            m_k++;
            m_err = 1'b0;
            if (c) begin
                for (int i = 0; i < 4; i++) m_hist[i] = 8'hFF;
                m_idx = 4'hF; m_cnt = 0;
            end else if (v) begin
                cls = class_of(s);
                if (cls >= 0) begin
                    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                    m_hist[0] = s;
                    m_idx = 4'(cls);
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("seg_out", 32'(seg_out), 32'(e_seg));
        check_eq("an_out", 32'(an_out), 32'(e_an));
        check_eq("digit_idx", 32'(digit_idx), 32'(m_idx));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("result_cnt", 32'(result_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; seg_valid = 1'b0; seg_in = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'hA4);
        // Free-running scan with empty history.
        idle(20);
        step(1'b0, 1'b0, 1'b1, 8'hA4);
        idle(18);
        // Back-to-back strobes fill the history.
        step(1'b0, 1'b0, 1'b1, 8'hF9);
        step(1'b0, 1'b0, 1'b1, 8'hB0);
        step(1'b0, 1'b0, 1'b1, 8'h99);
        step(1'b0, 1'b0, 1'b1, 8'h92);
        idle(17);
        // Invalid code, then clear colliding with a valid strobe.
        step(1'b0, 1'b0, 1'b1, 8'h7F);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 8'h80);
        idle(17);
        // Saturate the counter.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1, codes[$urandom_range(9, 0)]);
        idle(3);
        // Reset mid-scan, with a coincident strobe that must be lost.
        step(1'b1, 1'b0, 1'b1, 8'h80);
        idle(10);
        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            logic r_s, c_s, v_s;
            logic [7:0] s_s;
            r_s = ($urandom_range(199, 0) == 0);
            c_s = ($urandom_range(49, 0) == 0);
            v_s = ($urandom_range(2, 0) == 0);
            s_s = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0))
                                               : codes[$urandom_range(9, 0)];
            step(r_s, c_s, v_s, s_s);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
